// File: rtl/y86_pkg.sv
// Shared Y86 memory-stage definitions: icodes, memory FSM states, decode result type.
package y86_pkg;

  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam int unsigned MEM_WORDS_DEF = 1024;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} mem_state_e;

  typedef enum logic {ADDR_VALE, ADDR_VALA} addr_sel_e;
  typedef enum logic {DATA_VALA, DATA_VALP} data_sel_e;

  typedef struct packed {
    logic      is_read;
    logic      is_write;
    addr_sel_e addr_sel;
    data_sel_e data_sel;
  } mem_op_t;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational icode -> memory action decode for the memory stage.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output mem_op_t    op_o
);

  always_comb begin
    op_o = '{is_read: 1'b0, is_write: 1'b0, addr_sel: ADDR_VALE, data_sel: DATA_VALA};
    case (icode_i)
      IMRMOVQ: op_o.is_read = 1'b1;
      IRET, IPOPQ: begin
        op_o.is_read  = 1'b1;
        op_o.addr_sel = ADDR_VALA;
      end
      IRMMOVQ, IPUSHQ: op_o.is_write = 1'b1;
      ICALL: begin
        op_o.is_write = 1'b1;
        op_o.data_sel = DATA_VALP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// Memory-stage initiator: issues one valid/ready request per instruction,
// waits for the response with a timeout, and reports val_m / bad_mem / done.
module mem_request_unit
  import y86_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  in_code,
  input  logic [63:0] val_e,
  input  logic [63:0] val_a,
  input  logic [63:0] val_p,
  output logic        busy,
  output logic        done,
  output logic [63:0] val_m,
  output logic        bad_mem,
  output logic        mreq_valid,
  output logic        mreq_write,
  output logic [63:0] mreq_addr,
  output logic [63:0] mreq_wdata,
  input  logic        mreq_ready,
  input  logic        mresp_valid,
  input  logic [63:0] mresp_rdata
);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       val_m_q, val_m_d;
  logic              bad_q, bad_d;

  mem_op_t           op;
  logic [63:0]       op_addr;
  logic [63:0]       op_wdata;
  logic              complete;
  logic              expired;

  mem_op_decode u_dec (
    .icode_i (in_code),
    .op_o    (op)
  );

  assign op_addr  = (op.addr_sel == ADDR_VALA) ? val_a : val_e;
  assign op_wdata = (op.data_sel == DATA_VALP) ? val_p : val_a;

  // Last cycle the responder is allowed to complete in.
  assign expired  = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    val_m_d  = val_m_q;
    bad_d    = bad_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bad_d = 1'b0;
          if (!op.is_read && !op.is_write) begin
            state_d = DONE;
          end else if (op_addr >= 64'(MEM_WORDS)) begin
            bad_d   = 1'b1;
            state_d = DONE;
          end else begin
            wr_d    = op.is_write;
            addr_d  = op_addr;
            wdata_d = op.is_write ? op_wdata : '0;
            cnt_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE, WAIT_RESP: begin
        cnt_d    = cnt_q + 1'b1;
        // A response in the handshake cycle itself completes the transaction.
        complete = mresp_valid && ((state_q == WAIT_RESP) || mreq_ready);
        if (complete) begin
          if (!wr_q) val_m_d = mresp_rdata;
          state_d = DONE;
        end else if (expired) begin
          bad_d   = 1'b1;
          state_d = DONE;
        end else if ((state_q == ISSUE) && mreq_ready) begin
          state_d = WAIT_RESP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      val_m_q    <= '0;
      bad_q      <= 1'b0;
      mreq_valid <= 1'b0;
      mreq_write <= 1'b0;
      mreq_addr  <= '0;
      mreq_wdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      val_m_q    <= val_m_d;
      bad_q      <= bad_d;
      // Request outputs are held at zero whenever the next state is not ISSUE.
      mreq_valid <= (state_d == ISSUE);
      mreq_write <= (state_d == ISSUE) ? wr_d    : 1'b0;
      mreq_addr  <= (state_d == ISSUE) ? addr_d  : '0;
      mreq_wdata <= (state_d == ISSUE) ? wdata_d : '0;
    end
  end

  assign busy    = (state_q == ISSUE) || (state_q == WAIT_RESP);
  assign done    = (state_q == DONE);
  assign val_m   = val_m_q;
  assign bad_mem = bad_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Self-checking bench for mem_request_unit: directed scenarios plus randomized
// transactions scored against a cycle-count reference model.
module tb_mem_request_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  in_code;
  logic [63:0] val_e, val_a, val_p;
  logic        busy, done, bad_mem;
  logic [63:0] val_m;
  logic        mreq_valid, mreq_write;
  logic [63:0] mreq_addr, mreq_wdata;
  logic        mreq_ready, mresp_valid;
  logic [63:0] mresp_rdata;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] prev_valm = '0;
  logic        prev_bad = 1'b0;

  always #5 clock = ~clock;

  mem_request_unit #(.MEM_WORDS(1024), .TIMEOUT(16), .CNT_W(5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .in_code     (in_code),
    .val_e       (val_e),
    .val_a       (val_a),
    .val_p       (val_p),
    .busy        (busy),
    .done        (done),
    .val_m       (val_m),
    .bad_mem     (bad_mem),
    .mreq_valid  (mreq_valid),
    .mreq_write  (mreq_write),
    .mreq_addr   (mreq_addr),
    .mreq_wdata  (mreq_wdata),
    .mreq_ready  (mreq_ready),
    .mresp_valid (mresp_valid),
    .mresp_rdata (mresp_rdata)
  );

  // kind: 0 none, 1 read, 2 write. Cycle 0 is the cycle start is presented.
  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] valm;
    logic        bad;
    logic        bad_addr;
    logic        tmo;
    int          done_t;
    int          nvalid;
  } exp_t;

  typedef struct {
    int          done_cnt;
    int          first_done;
    int          prof_err;
    logic        req_seen;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
  } obs_t;

  // Responder: ready in request cycle rdly, response ddly cycles later.
  // 16 request/response cycles are allowed before the timeout fires.
  function automatic exp_t model(input logic [3:0] ic, input logic [63:0] ve, va, vp, rd,
                                 input int rdly, ddly);
    exp_t e;
    int   c;
    e.kind = 0; e.addr = '0; e.wdata = '0; e.valm = prev_valm;
    e.bad = 1'b0; e.bad_addr = 1'b0; e.tmo = 1'b0; e.done_t = 1; e.nvalid = 0;
    case (ic)
      4'd5:        begin e.kind = 1; e.addr = ve; end
      4'd9, 4'd11: begin e.kind = 1; e.addr = va; end
      4'd4, 4'd10: begin e.kind = 2; e.addr = ve; e.wdata = va; end
      4'd8:        begin e.kind = 2; e.addr = ve; e.wdata = vp; end
      default: ;
    endcase
    if (e.kind != 0) begin
      if (e.addr >= 64'd1024) begin
        e.bad = 1'b1; e.bad_addr = 1'b1;
      end else begin
        c = rdly + ddly;
        e.nvalid = ((rdly < 16) ? rdly : 15) + 1;
        if (rdly < 16 && c < 16) begin
          e.done_t = c + 2;
          if (e.kind == 1) e.valm = rd;
        end else begin
          e.done_t = 17; e.bad = 1'b1; e.tmo = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic run_txn(input logic [3:0] ic, input logic [63:0] ve, va, vp, rd,
                         input int rdly, ddly, output exp_t e, output obs_t o);
    logic        eb, ev, ebad;
    logic [63:0] evm;
    int          k;
    e = model(ic, ve, va, vp, rd, rdly, ddly);
    o.done_cnt = 0; o.first_done = -1; o.prof_err = 0;
    o.req_seen = 1'b0; o.req_write = 1'b0; o.req_addr = '0; o.req_wdata = '0;
    for (int t = 0; t <= e.done_t + 1; t++) begin
      @(negedge clock);
      eb   = (e.kind != 0) && !e.bad_addr && t >= 1 && t < e.done_t;
      ev   = (e.kind != 0) && !e.bad_addr && t >= 1 && t <= e.nvalid;
      ebad = (t == 0) ? prev_bad : (e.bad_addr || (e.tmo && t >= e.done_t));
      evm  = (t >= e.done_t) ? e.valm : prev_valm;
      if (busy !== eb || mreq_valid !== ev || done !== (t == e.done_t) ||
          bad_mem !== ebad || val_m !== evm) o.prof_err++;
      if (ev) begin
        if (mreq_addr !== e.addr || mreq_wdata !== e.wdata || mreq_write !== (e.kind == 2))
          o.prof_err++;
      end else if (mreq_addr !== '0 || mreq_wdata !== '0 || mreq_write !== 1'b0) begin
        o.prof_err++;
      end
      if (done === 1'b1) begin
        o.done_cnt++;
        if (o.first_done < 0) o.first_done = t;
      end
      if (mreq_valid === 1'b1 && !o.req_seen) begin
        o.req_seen = 1'b1; o.req_write = mreq_write;
        o.req_addr = mreq_addr; o.req_wdata = mreq_wdata;
      end
      // Drive cycle t; inputs other than the responder are junk once start is taken.
      k = t - 1;
      if (t == 0) begin
        start = 1'b1; in_code = ic; val_e = ve; val_a = va; val_p = vp;
      end else begin
        start   = (t <= e.done_t) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_code = 4'($urandom);
        val_e   = {$urandom, $urandom};
        val_a   = {$urandom, $urandom};
        val_p   = {$urandom, $urandom};
      end
      mreq_ready  = (k >= 0 && k == rdly);
      mresp_valid = (k >= 0 && k == rdly + ddly);
      mresp_rdata = mresp_valid ? rd : {$urandom, $urandom};
    end
    start = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b0;
    prev_valm = e.valm;
    prev_bad  = e.bad;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; start = 1'b0; in_code = '0; val_e = '0; val_a = '0; val_p = '0;
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_rdata = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({busy, done, bad_mem, mreq_valid, mreq_write} !== 5'b0 ||
        val_m !== '0 || mreq_addr !== '0 || mreq_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b bad=%b valid=%b val_m=%h addr=%h want all 0",
               busy, done, bad_mem, mreq_valid, val_m, mreq_addr);
    end
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mrmovq_wait;
    exp_t e; obs_t o;
    run_txn(4'd5, 64'd3, 64'd99, 64'd77, 64'd8, 2, 1, e, o);
    vectors++;
    if (o.prof_err != 0) begin
      miscompares++; $display("FAIL mrmovq_profile: %0d bad cycles, want 0", o.prof_err);
    end
    vectors++;
    if (o.req_addr !== 64'd3 || o.req_write !== 1'b0) begin
      miscompares++;
      $display("FAIL mrmovq_req: addr=%0d write=%b want 3 0", o.req_addr, o.req_write);
    end
    vectors++;
    if (val_m !== 64'd8 || o.done_cnt != 1) begin
      miscompares++;
      $display("FAIL mrmovq_result: val_m=%0d done_cnt=%0d want 8 1", val_m, o.done_cnt);
    end
  endtask

  task automatic test_call_zero_wait;
    exp_t e; obs_t o;
    run_txn(4'd8, 64'd20, 64'd5, 64'h40, 64'hdead, 0, 0, e, o);
    vectors++;
    if (o.req_write !== 1'b1 || o.req_addr !== 64'd20 || o.req_wdata !== 64'h40) begin
      miscompares++;
      $display("FAIL call_req: write=%b addr=%0d wdata=%h want 1 20 40",
               o.req_write, o.req_addr, o.req_wdata);
    end
    vectors++;
    if (o.first_done != 2 || val_m !== 64'd8) begin
      miscompares++;
      $display("FAIL call_done: done_at=%0d val_m=%0d want 2 8", o.first_done, val_m);
    end
    vectors++;
    if (o.prof_err != 0) begin
      miscompares++; $display("FAIL call_profile: %0d bad cycles, want 0", o.prof_err);
    end
  endtask

  task automatic test_popq;
    exp_t e; obs_t o;
    run_txn(4'd11, 64'd8, 64'd7, 64'd0, 64'h1234, 1, 0, e, o);
    vectors++;
    if (o.req_addr !== 64'd7 || o.req_write !== 1'b0) begin
      miscompares++;
      $display("FAIL popq_addr: addr=%0d write=%b want 7 0", o.req_addr, o.req_write);
    end
    vectors++;
    if (val_m !== 64'h1234 || o.prof_err != 0) begin
      miscompares++;
      $display("FAIL popq_result: val_m=%h prof_err=%0d want 1234 0", val_m, o.prof_err);
    end
  endtask

  task automatic test_bad_addr;
    exp_t e; obs_t o;
    run_txn(4'd4, 64'd1024, 64'd5, 64'd0, 64'd0, 0, 0, e, o);
    vectors++;
    if (o.req_seen !== 1'b0 || bad_mem !== 1'b1 || o.first_done != 1) begin
      miscompares++;
      $display("FAIL bad_addr: req_seen=%b bad=%b done_at=%0d want 0 1 1",
               o.req_seen, bad_mem, o.first_done);
    end
    run_txn(4'd5, 64'd1023, 64'd0, 64'd0, 64'h55, 0, 0, e, o);
    vectors++;
    if (bad_mem !== 1'b0 || val_m !== 64'h55 || o.req_addr !== 64'd1023) begin
      miscompares++;
      $display("FAIL top_addr: bad=%b val_m=%h addr=%0d want 0 55 1023", bad_mem, val_m, o.req_addr);
    end
  endtask

  task automatic test_timeout;
    exp_t e; obs_t o;
    run_txn(4'd5, 64'd9, 64'd0, 64'd0, 64'h77, 1, 100, e, o);
    vectors++;
    if (bad_mem !== 1'b1 || o.first_done != 17 || val_m !== 64'h55) begin
      miscompares++;
      $display("FAIL timeout: bad=%b done_at=%0d val_m=%h want 1 17 55", bad_mem, o.first_done, val_m);
    end
    vectors++;
    if (o.prof_err != 0) begin
      miscompares++; $display("FAIL timeout_profile: %0d bad cycles, want 0", o.prof_err);
    end
    run_txn(4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, e, o);
    vectors++;
    if (bad_mem !== 1'b0 || o.first_done != 1) begin
      miscompares++;
      $display("FAIL timeout_clear: bad=%b done_at=%0d want 0 1", bad_mem, o.first_done);
    end
  endtask

  task automatic test_timeout_boundary;
    exp_t e; obs_t o;
    run_txn(4'd9, 64'd2000, 64'd12, 64'd0, 64'hbeef, 5, 10, e, o);
    vectors++;
    if (bad_mem !== 1'b0 || val_m !== 64'hbeef || o.first_done != 17) begin
      miscompares++;
      $display("FAIL last_cycle_completion: bad=%b val_m=%h done_at=%0d want 0 beef 17",
               bad_mem, val_m, o.first_done);
    end
    run_txn(4'd10, 64'd30, 64'h99, 64'd0, 64'd0, 16, 0, e, o);
    vectors++;
    if (bad_mem !== 1'b1 || o.prof_err != 0) begin
      miscompares++;
      $display("FAIL ready_too_late: bad=%b prof_err=%0d want 1 0", bad_mem, o.prof_err);
    end
  endtask

  task automatic test_random;
    exp_t        e; obs_t o;
    logic [63:0] ve, va;
    for (int n = 0; n < 30; n++) begin
      ve = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
      va = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
      run_txn(4'($urandom), ve, va, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 17), $urandom_range(0, 4), e, o);
      vectors++;
      if (o.prof_err != 0 || o.done_cnt != 1 || o.first_done != e.done_t) begin
        miscompares++;
        $display("FAIL random_%0d: prof_err=%0d done_cnt=%0d done_at=%0d want 0 1 %0d",
                 n, o.prof_err, o.done_cnt, o.first_done, e.done_t);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    start = 1'b1; in_code = 4'd5; val_e = 64'd10; val_a = '0; val_p = '0;
    @(negedge clock);
    start = 1'b0; mreq_ready = 1'b1;
    @(negedge clock);
    mreq_ready = 1'b0;
    vectors++;
    if (busy !== 1'b1 || mreq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_resp_state: busy=%b valid=%b want 1 0", busy, mreq_valid);
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bad_mem, mreq_valid, mreq_write} !== 5'b0 ||
        val_m !== '0 || mreq_addr !== '0 || mreq_wdata !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b bad=%b valid=%b val_m=%h want all 0",
               busy, done, bad_mem, mreq_valid, val_m);
    end
    @(negedge clock);
    reset_n = 1'b1; mresp_valid = 1'b1; mresp_rdata = 64'hcafe;
    @(negedge clock);
    mresp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || val_m !== '0) begin
        miscompares++;
        $display("FAIL late_resp_%0d: done=%b busy=%b val_m=%h want 0 0 0", i, done, busy, val_m);
      end
      @(negedge clock);
    end
    prev_valm = '0;
    prev_bad  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mrmovq_wait();
    test_call_zero_wait();
    test_popq();
    test_bad_addr();
    test_timeout();
    test_timeout_boundary();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Initiator side of the data-memory interface for the Y86 memory stage.
- Decodes the executing instruction's memory action from in_code, val_e, val_a and val_p.
- Issues one valid/ready request to a multi-cycle data-memory responder and waits for the response handshake.
- Returns val_m, flags bad_mem on an invalid address or timeout, and stalls the stage while the transaction is in flight.

Parameters:
- MEM_WORDS, 1024, number of 64-bit words behind the responder; a valid address is 0..MEM_WORDS-1.
- TIMEOUT, 16, cycles allowed from entering ISSUE until the response arrives.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  stage has a valid instruction; sampled only in IDLE.
- in_code  in  4  Y86 icode.
- val_e  in  64  ALU result.
- val_a  in  64  register A value.
- val_p  in  64  next PC.
- busy  out  1  stall to fetch/decode; high in ISSUE and WAIT_RESP.
- done  out  1  one-cycle pulse: instruction's memory phase complete.
- val_m  out  64  read data.
- bad_mem  out  1  address or timeout error for the current instruction.
- mreq_valid  out  1  request valid.
- mreq_write  out  1  1 = write, 0 = read.
- mreq_addr  out  64  word address.
- mreq_wdata  out  64  write data.
- mreq_ready  in  1  responder accepts the request.
- mresp_valid  in  1  responder completes; rdata is valid for reads.
- mresp_rdata  in  64  read data.

Behaviour:
- Reset (async, active low): state IDLE; all outputs 0, including val_m, bad_mem and the mreq_* outputs; timeout counter 0. Reset mid-transaction abandons the transaction, and any later mresp_valid seen in IDLE is ignored.
- Decode, using registered copies latched when start is accepted:
  - 5 mrmovq: read at val_e.
  - 9 ret, 11 popq: read at val_a.
  - 4 rmmovq, 10 pushq: write val_a at val_e.
  - 8 call: write val_p at val_e.
  - Any other icode: no memory operation.
- IDLE, start = 1:
  - clear bad_mem;
  - no-op icode → DONE;
  - address >= MEM_WORDS (unsigned, full 64 bits) → set bad_mem, go to DONE, no request issued;
  - otherwise latch addr/wdata/write, clear the counter, go to ISSUE.
- In any state other than IDLE, start is ignored.
- ISSUE:
  - mreq_valid = 1; addr, wdata and write stay stable until the handshake.
  - On mreq_ready, go to WAIT_RESP.
  - If mresp_valid is also high in that same cycle, complete directly: capture data for a read and go to DONE.
- WAIT_RESP: on mresp_valid, latch mresp_rdata into val_m for a read only, then go to DONE. Writes leave val_m unchanged.
- Timeout:
  - The counter increments each cycle in ISSUE and WAIT_RESP.
  - When it reaches TIMEOUT with no completion: set bad_mem, deassert mreq_valid, go to DONE.
  - If completion and timeout fall in the same cycle, completion wins and bad_mem stays 0.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
  - val_m holds until the next read completes.
  - bad_mem holds until the next start is accepted.
- busy: combinational from state; high in ISSUE and WAIT_RESP.
- Latency with a zero-wait responder (ready and resp in the ISSUE cycle):
  - start edge → ISSUE → DONE, so done is high 2 cycles after start.
  - No-op or bad address: done 1 cycle after start.
- mreq_valid, mreq_write, mreq_addr and mreq_wdata are registered outputs; they are 0 outside ISSUE.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IRMMOVQ = 4, IMRMOVQ = 5, ICALL = 8, IRET = 9, IPUSHQ = 10, IPOPQ = 11;
  - the memory-state enum: IDLE, ISSUE, WAIT_RESP, DONE;
  - MEM_WORDS default.
- One sub-module, mem_op_decode: combinational icode → {is_read, is_write, addr_sel, data_sel}. The FSM and timeout counter stay in the top module.

Test Plan:
- mrmovq (in_code 5), val_e = 3, responder ready in 2 cycles with resp 1 cycle later, rdata = 8 → mreq_addr = 3 with write = 0; val_m = 8; done pulses once; busy high throughout the wait.
- call (8), val_e = 20, val_p = 0x40, zero-wait responder → mreq_write = 1, addr 20, wdata 0x40; done 2 cycles after start; val_m unchanged.
- popq (11), val_a = 7, val_e = 8 → mreq_addr = 7, not 8.
- rmmovq (4), val_e = 1024 → no mreq_valid, bad_mem = 1, done 1 cycle after start.
- mrmovq, responder never asserts mresp_valid, TIMEOUT = 16 → bad_mem = 1 and done 16 cycles after ISSUE entry; the next start clears bad_mem.
- reset_n low for 1 cycle during WAIT_RESP, then a late mresp_valid → all outputs 0, state IDLE, the response is ignored, and no done pulse occurs.
